// File: rtl/door_motion_conditioner.sv
// Conditions the raw door PIR/motion line into a clean motion level: 2-FF synchroniser,
// debounce before a detection is accepted, and a hold timer that stretches each detection.
module door_motion_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int HOLD_CYCLES     = 50000,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw_motion,
  input  logic       enable,
  output logic       motion_detected,
  output logic       motion_event,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONFIRM = 2'd1,
    ACTIVE  = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DEBOUNCE_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST     = CNT_W'(HOLD_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             sync1;
  logic             sync2;

  // The synchroniser keeps running while disabled so sync2 is already valid on re-enable.
  // NOTE: non-blocking assignments make sync1->sync2 a true two-stage shift; blocking
  // ones would collapse the chain into a single flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw_motion;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      motion_detected <= 1'b0;
      motion_event    <= 1'b0;
    end else if (!enable) begin
      // Disabled means no motion, so the lock fails safe.
      state           <= IDLE;
      cnt             <= '0;
      motion_detected <= 1'b0;
      motion_event    <= 1'b0;
    end else begin
      motion_event <= 1'b0;
      case (state)
        IDLE: begin
          motion_detected <= 1'b0;
          if (sync2) begin
            state <= CONFIRM;
            cnt   <= '0;
          end
        end
        CONFIRM: begin
          motion_detected <= 1'b0;
          if (!sync2) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DEBOUNCE_LAST) begin
            state           <= ACTIVE;
            motion_detected <= 1'b1;
            motion_event    <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ACTIVE: begin
          motion_detected <= 1'b1;
          if (!sync2) begin
            state <= HOLD;
            cnt   <= '0;
          end
        end
        HOLD: begin
          // Retrigger during hold goes straight back to ACTIVE without a new event.
          if (sync2) begin
            state           <= ACTIVE;
            cnt             <= '0;
            motion_detected <= 1'b1;
          end else if (cnt == HOLD_LAST) begin
            state           <= IDLE;
            motion_detected <= 1'b0;
          end else begin
            cnt             <= cnt + 1'b1;
            motion_detected <= 1'b1;
          end
        end
        default: begin
          state           <= IDLE;
          cnt             <= '0;
          motion_detected <= 1'b0;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_door_motion_conditioner.sv
// Scoreboard bench for door_motion_conditioner: stimulus queues hand-computed expected
// {motion_detected, motion_event, state_dbg} per clock; a monitor pops and compares.
module tb_door_motion_conditioner;

  localparam logic [3:0] E_IDLE  = 4'b0000;
  localparam logic [3:0] E_CONF  = 4'b0001;
  localparam logic [3:0] E_ACT   = 4'b1010;
  localparam logic [3:0] E_ACTEV = 4'b1110;
  localparam logic [3:0] E_HOLD  = 4'b1011;

  typedef struct {
    string      tag;
    logic [3:0] val;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       raw_motion;
  logic       enable;
  logic       motion_detected;
  logic       motion_event;
  logic [1:0] state_dbg;

  exp_t exp_q[$];
  int   total  = 0;
  int   passed = 0;

  door_motion_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (8),
    .CNT_W          (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .raw_motion     (raw_motion),
    .enable         (enable),
    .motion_detected(motion_detected),
    .motion_event   (motion_event),
    .state_dbg      (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected)
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    else
      passed++;
  endtask

  // Inputs change at the falling edge; the expectation applies after the next rising edge.
  task automatic step(input string tag, input logic raw, input logic en, input logic [3:0] val);
    exp_t e;
    @(negedge clk);
    raw_motion = raw;
    enable     = en;
    e.tag      = tag;
    e.val      = val;
    exp_q.push_back(e);
  endtask

  task automatic run(input string tag, input int n, input logic raw, input logic en,
                     input logic [3:0] val);
    for (int i = 0; i < n; i++) step(tag, raw, en, val);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.tag, {28'd0, motion_detected, motion_event, state_dbg}, {28'd0, e.val});
    end
  end

  initial begin
    rst        = 1'b1;
    raw_motion = 1'b0;
    enable     = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("reset_init", {motion_detected, motion_event, state_dbg}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    run("idle", 3, 1'b0, 1'b1, E_IDLE);

    // Clean detect: raw high from edge 0, accepted after edge 6.
    run("det_sync", 2, 1'b1, 1'b1, E_IDLE);
    run("det_confirm", 4, 1'b1, 1'b1, E_CONF);
    step("det_event", 1'b1, 1'b1, E_ACTEV);
    run("det_active", 2, 1'b1, 1'b1, E_ACT);

    // Retrigger: drop sampled at j, raise at j+6 -> FSM sees it in HOLD with cnt=5.
    run("rt_lag", 2, 1'b0, 1'b1, E_ACT);
    run("rt_hold", 4, 1'b0, 1'b1, E_HOLD);
    run("rt_hold_late", 2, 1'b1, 1'b1, E_HOLD);
    run("rt_active", 3, 1'b1, 1'b1, E_ACT);

    // Full hold and release: falls after edge j+10.
    run("hold_lag", 2, 1'b0, 1'b1, E_ACT);
    run("hold_stretch", 8, 1'b0, 1'b1, E_HOLD);
    run("hold_release", 3, 1'b0, 1'b1, E_IDLE);

    // Glitch of three samples is discarded.
    run("gl_sync", 2, 1'b1, 1'b1, E_IDLE);
    step("gl_confirm", 1'b1, 1'b1, E_CONF);
    run("gl_confirm_tail", 2, 1'b0, 1'b1, E_CONF);
    run("gl_reject", 3, 1'b0, 1'b1, E_IDLE);

    // Enable: disable in ACTIVE, re-enable with raw held high requires full debounce.
    run("en_sync", 2, 1'b1, 1'b1, E_IDLE);
    run("en_confirm", 4, 1'b1, 1'b1, E_CONF);
    step("en_event", 1'b1, 1'b1, E_ACTEV);
    step("en_active", 1'b1, 1'b1, E_ACT);
    run("en_off", 4, 1'b1, 1'b0, E_IDLE);
    run("en_reconfirm", 4, 1'b1, 1'b1, E_CONF);
    step("en_reevent", 1'b1, 1'b1, E_ACTEV);
    run("en_reactive", 2, 1'b1, 1'b1, E_ACT);

    // Asynchronous reset mid-ACTIVE, away from any clock edge.
    @(posedge clk);
    #4 rst = 1'b1;
    #1 check("reset_async", {motion_detected, motion_event, state_dbg}, 4'b0000);
    @(posedge clk);
    #1 check("reset_held", {motion_detected, motion_event, state_dbg}, 4'b0000);
    @(negedge clk);
    raw_motion = 1'b0;
    rst        = 1'b0;
    run("post_reset", 4, 1'b0, 1'b1, E_IDLE);

    repeat (3) @(posedge clk);
    #3 check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/door_motion_conditioner.md
Name: door_motion_conditioner

Overview:
Upstream conditioning stage for the door motion path. Takes the raw asynchronous door PIR/motion sensor line, synchronises it and debounces it, then stretches detections with a hold timer. Its output is the clean `door_motion_sensor` level (width `door_motion_sensor_data_width` = 1) consumed by door_lock_system, so that sensor glitches and short dropouts do not toggle the lock.

Parameters:
DEBOUNCE_CYCLES, 1000, consecutive synchronised-high cycles required to accept motion (>=1)
HOLD_CYCLES, 50000, cycles motion_detected stays high after the synchronised input drops (>=1)
CNT_W, 16, shared counter width; DEBOUNCE_CYCLES and HOLD_CYCLES must both be < 2**CNT_W

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
raw_motion  input  1  raw sensor line, asynchronous to clk
enable  input  1  synchronous conditioner enable; 0 forces no-motion (door locks, fail-safe)
motion_detected  output  1  conditioned motion level; drives door_lock_system door_motion_sensor
motion_event  output  1  one-cycle pulse on each newly accepted motion
state_dbg  output  2  current FSM state encoding, for debug

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-high (rst).
- All outputs, sync flops, counter and state are registered.
- Reset values: state=IDLE, cnt=0, sync1=sync2=0, motion_detected=0, motion_event=0, state_dbg=2'd0.
- Reset assertion mid-operation clears everything immediately, without waiting for clk.
- Synchroniser: 2-FF chain raw_motion->sync1->sync2. It runs regardless of enable. The FSM sees only sync2.
- State encoding: IDLE=0, CONFIRM=1, ACTIVE=2, HOLD=3. All transitions and output updates occur on the same clk edge.
- IDLE:
  - motion_detected=0.
  - sync2=1 -> CONFIRM, cnt<=0.
- CONFIRM:
  - motion_detected=0.
  - sync2=0 -> IDLE, cnt<=0. A glitch is discarded with no output.
  - sync2=1 and cnt==DEBOUNCE_CYCLES-1 -> ACTIVE, motion_detected<=1, motion_event<=1 for exactly one cycle.
  - Otherwise cnt<=cnt+1.
- ACTIVE:
  - motion_detected=1.
  - sync2=0 -> HOLD, cnt<=0.
  - Otherwise stay in ACTIVE.
- HOLD:
  - motion_detected=1.
  - sync2=1 -> ACTIVE, cnt<=0. This retrigger needs no re-debounce and raises no motion_event.
  - sync2=0 and cnt==HOLD_CYCLES-1 -> IDLE, motion_detected<=0.
  - Otherwise cnt<=cnt+1.
- Latency: raw high first sampled at edge k -> motion_detected high after edge k+2+DEBOUNCE_CYCLES, with motion_event high for that one cycle. Raw low first sampled at edge j (from ACTIVE) -> motion_detected low after edge j+2+HOLD_CYCLES.
- enable=0 has priority over all FSM transitions. The next edge forces IDLE, cnt=0, motion_detected=0 and motion_event=0, and these hold while enable=0. When enable returns to 1, operation restarts from IDLE using the current sync2 value, so a full debounce is required again.
- motion_event is asserted only on the CONFIRM->ACTIVE transition. It is never asserted back-to-back.
- Counter never wraps: both terminal compares occur before cnt reaches 2**CNT_W-1 under the parameter constraint.

Test Plan:
All cases use DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, CNT_W=8.
1. Reset: rst pulsed asynchronously mid-ACTIVE -> motion_detected, motion_event, state_dbg all 0 immediately; stay IDLE after release with raw_motion=0.
2. Clean detect: raw_motion high from edge 0 -> motion_detected rises after edge 6; motion_event high for exactly the cycle after edge 6; state_dbg 0->1 after edge 2, ->2 after edge 6.
3. Glitch reject: raw_motion high for 3 cycles, then low -> motion_detected and motion_event stay 0; state_dbg returns to 0.
4. Hold and release: from ACTIVE, raw_motion low sampled at edge j -> motion_detected stays 1 through HOLD and falls after edge j+10; state_dbg 2->3->0.
5. Retrigger: in HOLD at cnt=5, raw_motion high -> back to ACTIVE with no motion_event; the hold period restarts in full on the next drop.
6. Enable: enable=0 while in ACTIVE -> motion_detected=0 on the next edge, state_dbg=0. Re-enable with raw_motion held high -> motion_detected returns 4 cycles after re-entering CONFIRM, and motion_event pulses once.
